// File: rtl/uart_resp_pkg.sv
// Shared constants and FSM state type for the UART command responder.
package uart_resp_pkg;

    localparam logic [7:0] CMD_WR       = 8'h57;
    localparam logic [7:0] CMD_RD       = 8'h52;
    localparam logic [7:0] RSP_OK       = 8'h4B;
    localparam logic [7:0] RSP_ERR      = 8'h45;
    localparam logic [7:0] RSP_BAD      = 8'h3F;
    localparam logic [7:0] VERSION_ADDR = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_GET_CSUM,
        ST_EXEC,
        ST_SEND
    } state_t;

endpackage

// File: rtl/uart_resp_regfile.sv
// NREGS x WIDTH register file: synchronous write, combinational read,
// one-cycle reg_wr pulse and sticky address of the last write.
module uart_resp_regfile #(
    parameter int WIDTH = 8,
    parameter int NREGS = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic [WIDTH-1:0]       addr,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic [NREGS*WIDTH-1:0] regs_out,
    output logic                   reg_wr,
    output logic [WIDTH-1:0]       reg_wr_addr
);

    logic [WIDTH-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NREGS; k++) mem[k] <= '0;
            reg_wr      <= 1'b0;
            reg_wr_addr <= '0;
        end else begin
            reg_wr <= we;
            if (we) begin
                reg_wr_addr <= addr;
                for (int k = 0; k < NREGS; k++)
                    if (addr == WIDTH'(k)) mem[k] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NREGS; k++)
            if (addr == WIDTH'(k)) rd_data = mem[k];
    end

    for (genvar k = 0; k < NREGS; k++) begin : g_flat
        assign regs_out[k*WIDTH +: WIDTH] = mem[k];
    end

endmodule

// File: rtl/uart_cmd_responder.sv
// UART FIFO-side command responder: parses 'W'/'R' frames, executes them on
// the register file, answers one byte per frame. Optional checksum byte
// per frame when UART_RESP_CSUM_EN is defined.
module uart_cmd_responder
    import uart_resp_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               NREGS   = 8,
    parameter logic [WIDTH-1:0] VERSION = 8'h01,
    parameter int               TIMEOUT = 25000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       r_data,
    input  logic                   rx_fifo_empty,
    output logic                   rd_uart,
    input  logic                   tx_fifo_full,
    output logic                   wr_uart,
    output logic [WIDTH-1:0]       w_data,
    output logic [NREGS*WIDTH-1:0] regs_out,
    output logic                   reg_wr,
    output logic [WIDTH-1:0]       reg_wr_addr
);

    localparam int               CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [WIDTH:0]   NREGS_L    = (WIDTH+1)'(NREGS);
    localparam logic [WIDTH-1:0] W_CMD_WR   = WIDTH'(CMD_WR);
    localparam logic [WIDTH-1:0] W_CMD_RD   = WIDTH'(CMD_RD);
    localparam logic [WIDTH-1:0] W_RSP_OK   = WIDTH'(RSP_OK);
    localparam logic [WIDTH-1:0] W_RSP_ERR  = WIDTH'(RSP_ERR);
    localparam logic [WIDTH-1:0] W_RSP_BAD  = WIDTH'(RSP_BAD);
    localparam logic [WIDTH-1:0] W_VER_ADDR = WIDTH'(VERSION_ADDR);

    state_t            state, next_state;
    logic [CNT_W-1:0]  cnt;
    logic              is_wr;
    logic [WIDTH-1:0]  addr_q, data_q, rd_data, resp;
    logic              pop, is_cmd, in_range, we, timeout_hit, in_frame;
    logic              csum_ok;

`ifdef UART_RESP_CSUM_EN
    logic [WIDTH-1:0]  csum_q;
    logic              csum_match;
`else
    assign csum_ok = 1'b1;
`endif

    assign pop         = rd_uart;
    assign is_cmd      = (r_data == W_CMD_WR) || (r_data == W_CMD_RD);
    assign in_range    = {1'b0, addr_q} < NREGS_L;
    assign we          = (state == ST_EXEC) && is_wr && in_range && csum_ok;
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
    assign in_frame    = (state == ST_GET_ADDR) || (state == ST_GET_DATA) ||
                         (state == ST_GET_CSUM);

    always_comb begin
        next_state = state;
        rd_uart    = 1'b0;
        wr_uart    = 1'b0;
        case (state)
            ST_IDLE: begin
                rd_uart = !rx_fifo_empty;
                if (pop) next_state = is_cmd ? ST_GET_ADDR : ST_SEND;
            end
            ST_GET_ADDR: begin
                rd_uart = !rx_fifo_empty;
                if (pop) begin
`ifdef UART_RESP_CSUM_EN
                    next_state = is_wr ? ST_GET_DATA : ST_GET_CSUM;
`else
                    next_state = is_wr ? ST_GET_DATA : ST_EXEC;
`endif
                end else if (timeout_hit) begin
                    next_state = ST_IDLE;
                end
            end
            ST_GET_DATA: begin
                rd_uart = !rx_fifo_empty;
                if (pop) begin
`ifdef UART_RESP_CSUM_EN
                    next_state = ST_GET_CSUM;
`else
                    next_state = ST_EXEC;
`endif
                end else if (timeout_hit) begin
                    next_state = ST_IDLE;
                end
            end
`ifdef UART_RESP_CSUM_EN
            ST_GET_CSUM: begin
                rd_uart = !rx_fifo_empty;
                if (pop)              next_state = ST_EXEC;
                else if (timeout_hit) next_state = ST_IDLE;
            end
`endif
            ST_EXEC: next_state = ST_SEND;
            ST_SEND: begin
                wr_uart = !tx_fifo_full;
                if (!tx_fifo_full) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // A failed checksum turns every frame into an error, including reads.
    always_comb begin
        resp = W_RSP_ERR;
        if (csum_ok) begin
            if (is_wr) begin
                if (in_range) resp = W_RSP_OK;
            end else if (addr_q == W_VER_ADDR) begin
                resp = VERSION;
            end else if (in_range) begin
                resp = rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            is_wr  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            w_data <= '0;
        end else begin
            state <= next_state;
            if (pop || !in_frame) cnt <= '0;
            else                  cnt <= cnt + CNT_W'(1);
            if (pop) begin
                case (state)
                    ST_IDLE: begin
                        is_wr <= (r_data == W_CMD_WR);
                        if (!is_cmd) w_data <= W_RSP_BAD;
                    end
                    ST_GET_ADDR: addr_q <= r_data;
                    ST_GET_DATA: data_q <= r_data;
                    default: ;
                endcase
            end
            if (state == ST_EXEC) w_data <= resp;
        end
    end

`ifdef UART_RESP_CSUM_EN
    assign csum_match = (r_data == csum_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q  <= '0;
            csum_ok <= 1'b0;
        end else if (pop) begin
            if (state == ST_IDLE) begin
                csum_q  <= r_data;
                csum_ok <= 1'b1;
            end else if (state == ST_GET_CSUM) begin
                csum_ok <= csum_match;
            end else begin
                csum_q  <= csum_q ^ r_data;
            end
        end
    end
`endif

    uart_resp_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk         (clk),
        .reset       (reset),
        .we          (we),
        .addr        (addr_q),
        .wr_data     (data_q),
        .rd_data     (rd_data),
        .regs_out    (regs_out),
        .reg_wr      (reg_wr),
        .reg_wr_addr (reg_wr_addr)
    );

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Bench for uart_cmd_responder with queue-based RX/TX FIFO models and a
// frame-level reference model; also covers UART_RESP_CSUM_EN builds.
module tb_uart_cmd_responder;

    localparam int NREGS   = 8;
    localparam int TIMEOUT = 40;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        r_data;
    logic              rx_fifo_empty;
    logic              rd_uart;
    logic              tx_fifo_full;
    logic              wr_uart;
    logic [7:0]        w_data;
    logic [NREGS*8-1:0] regs_out;
    logic              reg_wr;
    logic [7:0]        reg_wr_addr;

    uart_cmd_responder #(
        .WIDTH   (8),
        .NREGS   (NREGS),
        .VERSION (8'h01),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .r_data        (r_data),
        .rx_fifo_empty (rx_fifo_empty),
        .rd_uart       (rd_uart),
        .tx_fifo_full  (tx_fifo_full),
        .wr_uart       (wr_uart),
        .w_data        (w_data),
        .regs_out      (regs_out),
        .reg_wr        (reg_wr),
        .reg_wr_addr   (reg_wr_addr)
    );

    always #5 clk = ~clk;

    logic [7:0] rxq [$];
    logic [7:0] txq [$];
    logic [7:0] expq [$];
    logic [7:0] mregs [NREGS];
    int checks = 0;
    int errors = 0;
    int step_no = 0;
    int last_pop_step = 0;
    int last_push_step = 0;
    int nwr = 0;
    int exp_wr = 0;
    logic [7:0] last_wr_addr = 8'h00;
    bit rand_full = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        rx_fifo_empty = (rxq.size() == 0);
        r_data        = (rxq.size() != 0) ? rxq[0] : 8'h00;
    endtask

    // One clock: sample DUT handshakes mid-cycle, then apply FIFO effects after the edge.
    task automatic step();
        logic       do_pop, do_push;
        logic [7:0] pd;
        @(negedge clk);
        do_pop  = rd_uart;
        do_push = wr_uart;
        pd      = w_data;
        if (reg_wr === 1'b1) begin
            nwr++;
            last_wr_addr = reg_wr_addr;
        end
        if (do_pop)  last_pop_step  = step_no;
        if (do_push) last_push_step = step_no;
        @(posedge clk);
        #1;
        step_no++;
        if (do_pop && rxq.size() != 0) void'(rxq.pop_front());
        if (do_push) txq.push_back(pd);
        if (rand_full) tx_fifo_full = ($urandom_range(0, 3) == 0);
        refresh();
    endtask

    task automatic push_byte(input logic [7:0] b);
        rxq.push_back(b);
        refresh();
    endtask

    function automatic logic [7:0] model(input logic [7:0] c, input logic [7:0] a,
                                         input logic [7:0] d);
        if (c == 8'h57) begin
            if (a < NREGS) begin
                mregs[a[2:0]] = d;
                exp_wr++;
                return 8'h4B;
            end
            return 8'h45;
        end
        if (c == 8'h52) begin
            if (a == 8'hFF) return 8'h01;
            if (a < NREGS)  return mregs[a[2:0]];
            return 8'h45;
        end
        return 8'h3F;
    endfunction

    task automatic push_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d);
        push_byte(c);
        if (c == 8'h57 || c == 8'h52) begin
            push_byte(a);
            if (c == 8'h57) push_byte(d);
`ifdef UART_RESP_CSUM_EN
            push_byte((c == 8'h57) ? (c ^ a ^ d) : (c ^ a));
`endif
        end
        expq.push_back(model(c, a, d));
    endtask

    task automatic run_resp(input int n, input int budget, input string tag);
        int b = 0;
        while (txq.size() < n && b < budget) begin
            step();
            b++;
        end
        chk(tag, txq.size() >= n, 1'b1);
    endtask

    task automatic drain_rx(input int budget);
        int b = 0;
        while (rxq.size() != 0 && b < budget) begin
            step();
            b++;
        end
        chk("rx_drain", rxq.size(), 0);
    endtask

    function automatic logic [7:0] reg_of(input int k);
        return regs_out[k*8 +: 8];
    endfunction

    initial begin
        int nwr0;
        for (int k = 0; k < NREGS; k++) mregs[k] = 8'h00;
        reset = 1'b1;
        tx_fifo_full = 1'b0;
        refresh();
        repeat (3) step();

        chk("rst_rd_uart", rd_uart, 1'b0);
        chk("rst_wr_uart", wr_uart, 1'b0);
        chk("rst_w_data", w_data, 8'h00);
        chk("rst_regs", regs_out, 64'h0);
        chk("rst_reg_wr", reg_wr, 1'b0);
        chk("rst_reg_wr_addr", reg_wr_addr, 8'h00);
        reset = 1'b0;
        step();

        // write then read back
        txq.delete(); expq.delete(); nwr0 = nwr;
        push_frame(8'h57, 8'h03, 8'hA5);
        push_frame(8'h52, 8'h03, 8'h00);
        run_resp(2, 200, "wr_rd_wait");
        chk("wr_rsp", txq[0], 8'h4B);
        chk("rd_rsp", txq[1], 8'hA5);
        chk("wr_reg3", reg_of(3), 8'hA5);
        chk("wr_pulses", nwr - nwr0, 1);
        chk("wr_addr", last_wr_addr, 8'h03);

        // version, write to FF, out-of-range read
        repeat (5) step();
        txq.delete(); expq.delete(); nwr0 = nwr;
        push_frame(8'h52, 8'hFF, 8'h00);
        push_frame(8'h57, 8'hFF, 8'h12);
        push_frame(8'h52, 8'h08, 8'h00);
        run_resp(3, 300, "err_wait");
        chk("version", txq[0], 8'h01);
        chk("wr_ff_err", txq[1], 8'h45);
        chk("rd_oor_err", txq[2], 8'h45);
        repeat (5) step();
        chk("err_no_wr", nwr - nwr0, 0);

        // unknown byte then read of reset-valued reg0
        txq.delete(); expq.delete();
        push_frame(8'h00, 8'h00, 8'h00);
        push_frame(8'h52, 8'h00, 8'h00);
        run_resp(2, 200, "bad_wait");
        chk("bad_rsp", txq[0], 8'h3F);
        chk("bad_next_rd", txq[1], 8'h00);

        // response latency: last request byte popped, push two cycles later
        repeat (5) step();
        txq.delete(); expq.delete();
        push_frame(8'h52, 8'h03, 8'h00);
        run_resp(1, 100, "lat_wait");
        chk("lat_data", txq[0], 8'hA5);
        chk("lat_cycles", last_push_step - last_pop_step, 2);

        // last legal gap before timeout: write still completes
        repeat (5) step();
        txq.delete(); expq.delete();
        push_byte(8'h57);
        push_byte(8'h04);
        drain_rx(50);
        repeat (TIMEOUT - 1) step();
        push_byte(8'h77);
`ifdef UART_RESP_CSUM_EN
        push_byte(8'h57 ^ 8'h04 ^ 8'h77);
`endif
        void'(model(8'h57, 8'h04, 8'h77));
        run_resp(1, 100, "to_edge_wait");
        chk("to_edge_rsp", txq[0], 8'h4B);
        chk("to_edge_reg4", reg_of(4), 8'h77);

        // full timeout: partial write abandoned silently
        repeat (5) step();
        txq.delete(); expq.delete();
        push_byte(8'h57);
        push_byte(8'h02);
        drain_rx(50);
        repeat (TIMEOUT) step();
        push_frame(8'h52, 8'h02, 8'h00);
        run_resp(1, 100, "to_wait");
        repeat (50) step();
        chk("to_count", txq.size(), 1);
        chk("to_rsp", txq[0], 8'h00);
        chk("to_reg2", reg_of(2), 8'h00);

        // TX backpressure
        txq.delete(); expq.delete();
        tx_fifo_full = 1'b1;
        push_frame(8'h52, 8'h03, 8'h00);
        repeat (10) step();
        chk("bp_wr_low", wr_uart, 1'b0);
        chk("bp_w_data", w_data, 8'hA5);
        repeat (20) step();
        chk("bp_wr_low2", wr_uart, 1'b0);
        chk("bp_w_data2", w_data, 8'hA5);
        chk("bp_no_push", txq.size(), 0);
        tx_fifo_full = 1'b0;
        repeat (10) step();
        chk("bp_one_push", txq.size(), 1);
        chk("bp_push_data", txq[0], 8'hA5);

`ifdef UART_RESP_CSUM_EN
        // checksum good then bad
        txq.delete(); expq.delete(); nwr0 = nwr;
        push_byte(8'h57); push_byte(8'h01); push_byte(8'h33); push_byte(8'h65);
        void'(model(8'h57, 8'h01, 8'h33));
        push_byte(8'h57); push_byte(8'h01); push_byte(8'h44); push_byte(8'h00);
        run_resp(2, 200, "cs_wait");
        chk("cs_ok_rsp", txq[0], 8'h4B);
        chk("cs_bad_rsp", txq[1], 8'h45);
        chk("cs_reg1", reg_of(1), 8'h33);
        repeat (5) step();
        chk("cs_wr_pulses", nwr - nwr0, 1);
`endif

        // randomized frames with random TX backpressure
        txq.delete(); expq.delete(); nwr0 = nwr; exp_wr = 0;
        for (int i = 0; i < 40; i++) begin
            int         kind;
            logic [7:0] a, b;
            kind = $urandom_range(0, 9);
            a = ($urandom_range(0, 11) == 11) ? 8'hFF : 8'($urandom_range(0, 10));
            b = 8'($urandom_range(0, 255));
            if (kind == 0) begin
                if (b == 8'h57 || b == 8'h52) b = b ^ 8'h01;
                push_frame(b, 8'h00, 8'h00);
            end else if (kind < 5) begin
                push_frame(8'h57, a, b);
            end else begin
                push_frame(8'h52, a, 8'h00);
            end
        end
        rand_full = 1'b1;
        run_resp(expq.size(), 5000, "rand_wait");
        rand_full = 1'b0;
        tx_fifo_full = 1'b0;
        repeat (20) step();
        chk("rand_count", txq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < txq.size(); i++)
            chk($sformatf("rand_rsp%0d", i), txq[i], expq[i]);
        for (int k = 0; k < NREGS; k++)
            chk($sformatf("rand_reg%0d", k), reg_of(k), mregs[k]);
        chk("rand_wr_pulses", nwr - nwr0, exp_wr);

        // reset mid-frame discards the partial frame
        txq.delete();
        push_byte(8'h57);
        push_byte(8'h05);
        drain_rx(20);
        reset = 1'b1;
        step();
        reset = 1'b0;
        push_frame(8'h52, 8'h05, 8'h00);
        run_resp(1, 100, "rst_mid_wait");
        chk("rst_mid_rsp", txq[0], 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
